ahb_bus_matrix_input_stage_s0: RTL and testbench
================================================

# ahb_bus_matrix_input_stage_s0

Slave-side input stage for bus matrix port S0, directly upstream of the S0 decoder. It registers each master address phase that the decoder's selected output stage cannot accept immediately. It holds the master in a wait-stated data phase until arbitration grants it, then replays the held address and control to the decoder. When no transfer is held, address/control pass straight through and the decoder's data-phase response is returned unchanged.

## Interface
Parameters: none.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset: asynchronous, active-low; clock HCLK
- HSELS  in  1  port select from master
- HADDRS  in  32  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  locked
- HAUSERS  in  32  address user sideband (only with macro)
- HREADYS  in  1  bus-wide HREADY seen by the master
- sel_op  out  1  select to decoder
- addr_op  out  32  address to decoder (decoder uses [31:10])
- trans_op  out  2  HTRANS to decoder
- write_op, size_op, burst_op, prot_op, mastlock_op  out  1/3/3/4/1  control to decoder
- auser_op  out  32  address user sideband
- held_tran_op  out  1  high while a held transfer is presented
- active_ip  in  1  decoder active: selected output stage is serving S0
- readyout_ip  in  1  decoder HREADYOUT
- resp_ip  in  2  decoder HRESP
- HREADYOUTS  out  1  HREADYOUT to master
- HRESPS  out  2  HRESP to master

## Operation
- trans_req = HSELS & HTRANSS[1] & HREADYS. A transfer request is a NONSEQ or SEQ transfer accepted on HREADYS.
- Holding registers capture addr, trans, write, size, burst, prot, mastlock and auser on every HCLK edge with HREADYS=1 and pend=0. They are frozen while pend=1.
- pend register:
  - Set on trans_req & ~active_ip.
  - Cleared on pend & active_ip & readyout_ip, which is the held address phase accepted by the output stage.
  - Set has priority when both conditions hold in one cycle.
- Output mux, pend=1:
  - sel_op=1, all *_op outputs come from the holding registers, held_tran_op=1.
  - HREADYOUTS=0, HRESPS=2'b00 (OKAY).
- Output mux, pend=0:
  - sel_op=HSELS, all *_op outputs are the live inputs, held_tran_op=0.
  - HREADYOUTS=readyout_ip, HRESPS=resp_ip.
- IDLE/BUSY transfers never set pend. They pass through so the decoder can route them.
- HREADYS=1 while pend=1 is legal only with HSELS=0. In that case the holding registers and pend are unchanged.

## Timing
- Reset (HRESETn low):
  - pend=0 and all holding registers 0, asynchronously.
  - Outputs therefore take the pass-through values: sel_op=HSELS, HREADYOUTS=readyout_ip, held_tran_op=0.
- Pass-through path is purely combinational: 0-cycle latency.
- Held transfer timeline:
  - Accepted at edge N (pend becomes 1).
  - Presented to the decoder from cycle N onward.
  - Completes at the first edge M with active_ip & readyout_ip.
  - From cycle M, HREADYOUTS follows readyout_ip for the held data phase.
  - Master wait states = M-N cycles minimum (at least 1).
- Back-to-back: when pend clears at M, the master's next address is still stalled because HREADYOUTS=0 through cycle M-1. No transfer is lost or duplicated.
- Reset asserted mid-hold: the held transfer is discarded and HREADYOUTS reverts to readyout_ip in the same cycle.
- ERROR response with pend=0: the two-cycle HRESPS=01 sequence is passed through unchanged. A master cancelling to IDLE in the second cycle creates no hold.

## Configuration
- AHB_BUS_MATRIX_S0_AUSER_EN defined: HAUSERS port and a 32-bit auser holding register are present, and auser_op is muxed like the other control outputs.
- Not defined: the HAUSERS port is absent, no register is built, and auser_op is tied to 32'h0.

## Test plan
- Pass-through: HSELS=1, NONSEQ to 0x00010004, active_ip=1 → same cycle addr_op=0x00010004, held_tran_op=0, HREADYOUTS=readyout_ip.
- Hold: NONSEQ write to 0x10000010 with active_ip=0, then active_ip=1 after 3 cycles with readyout_ip=1 → HREADYOUTS=0 for 3 cycles, addr_op=0x10000010 throughout, held_tran_op drops after the completion edge.
- Live inputs change while held: HADDRS=0xDEAD0000 driven during pend → addr_op stays 0x10000010.
- IDLE with active_ip=0 → pend stays 0 and HREADYOUTS=readyout_ip.
- Reset mid-hold: HRESETn pulsed low at cycle 2 of a hold → held_tran_op=0 immediately, pend=0 after release.
- Macro build pair: with the macro, HAUSERS=0x5A5A5A5A held → auser_op=0x5A5A5A5A while pend=1; without the macro, auser_op=0.

Source files
------------

// File: rtl/ahb_bus_matrix_input_stage_s0.sv
// ahb_bus_matrix_input_stage_s0: S0 input stage; holds address phases the output stage cannot take yet and replays them.
// Define AHB_BUS_MATRIX_S0_AUSER_EN to add the HAUSERS sideband port and its holding register.
module ahb_bus_matrix_input_stage_s0 (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
`ifdef AHB_BUS_MATRIX_S0_AUSER_EN
  input  logic [31:0] HAUSERS,
`endif
  input  logic        HREADYS,
  output logic        sel_op,
  output logic [31:0] addr_op,
  output logic [1:0]  trans_op,
  output logic        write_op,
  output logic [2:0]  size_op,
  output logic [2:0]  burst_op,
  output logic [3:0]  prot_op,
  output logic        mastlock_op,
  output logic [31:0] auser_op,
  output logic        held_tran_op,
  input  logic        active_ip,
  input  logic        readyout_ip,
  input  logic [1:0]  resp_ip,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS
);
  logic        pend_q, pend_d, trans_req, capture;
  logic [31:0] addr_q;
  logic [1:0]  trans_q;
  logic        write_q, mastlock_q;
  logic [2:0]  size_q, burst_q;
  logic [3:0]  prot_q;
  assign trans_req = HSELS & HTRANSS[1] & HREADYS;
  // Capture every accepted address phase; only those the decoder refuses are ever replayed.
  assign capture = HREADYS & ~pend_q;
  always_comb pend_d = (trans_req & ~active_ip) ? 1'b1 : (pend_q & active_ip & readyout_ip) ? 1'b0 : pend_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q     <= 1'b0;
      addr_q     <= '0;
      trans_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      prot_q     <= '0;
      mastlock_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (capture) begin
        addr_q     <= HADDRS;
        trans_q    <= HTRANSS;
        write_q    <= HWRITES;
        size_q     <= HSIZES;
        burst_q    <= HBURSTS;
        prot_q     <= HPROTS;
        mastlock_q <= HMASTLOCKS;
      end
    end
  end
`ifdef AHB_BUS_MATRIX_S0_AUSER_EN
  logic [31:0] auser_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) auser_q <= '0;
    else if (capture) auser_q <= HAUSERS;
  end
  assign auser_op = pend_q ? auser_q : HAUSERS;
`else
  assign auser_op = 32'h0;
`endif
  assign sel_op       = pend_q | HSELS;
  assign addr_op      = pend_q ? addr_q : HADDRS;
  assign trans_op     = pend_q ? trans_q : HTRANSS;
  assign write_op     = pend_q ? write_q : HWRITES;
  assign size_op      = pend_q ? size_q : HSIZES;
  assign burst_op     = pend_q ? burst_q : HBURSTS;
  assign prot_op      = pend_q ? prot_q : HPROTS;
  assign mastlock_op  = pend_q ? mastlock_q : HMASTLOCKS;
  assign held_tran_op = pend_q;
  // The master sits in a wait-stated OKAY data phase until the held address is taken.
  assign HREADYOUTS   = pend_q ? 1'b0 : readyout_ip;
  assign HRESPS       = pend_q ? 2'b00 : resp_ip;
endmodule

// File: tb/tb_ahb_bus_matrix_input_stage_s0.sv
// tb_ahb_bus_matrix_input_stage_s0: scoreboard bench for the S0 input stage (pass-through, hold, reset, back-to-back).
module tb_ahb_bus_matrix_input_stage_s0;
`ifdef AHB_BUS_MATRIX_S0_AUSER_EN
  localparam bit AU = 1'b1;
`else
  localparam bit AU = 1'b0;
`endif
  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  typedef struct packed {
    logic        sel;
    logic        held;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic [31:0] auser;
  } out_t;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS, active_ip, readyout_ip;
  logic [31:0] HADDRS, HAUSERS;
  logic [1:0]  HTRANSS, resp_ip, trans_op, HRESPS;
  logic [2:0]  HSIZES, HBURSTS, size_op, burst_op;
  logic [3:0]  HPROTS, prot_op;
  logic        sel_op, write_op, mastlock_op, held_tran_op, HREADYOUTS;
  logic [31:0] addr_op, auser_op;
  out_t        obs, e;
  out_t        sb[$];
  int          checks = 0, passed = 0;
  always #5 HCLK = ~HCLK;
  ahb_bus_matrix_input_stage_s0 dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
`ifdef AHB_BUS_MATRIX_S0_AUSER_EN
    .HAUSERS(HAUSERS),
`endif
    .HREADYS(HREADYS), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .mastlock_op(mastlock_op),
    .auser_op(auser_op), .held_tran_op(held_tran_op), .active_ip(active_ip), .readyout_ip(readyout_ip),
    .resp_ip(resp_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );
  assign obs = {sel_op, held_tran_op, HREADYOUTS, HRESPS, addr_op, trans_op, write_op,
                size_op, burst_op, prot_op, mastlock_op, auser_op};
  // Control fields are derived from the address so each address carries a distinct control set.
  function automatic out_t mk(logic sel, logic held, logic rdy, logic [1:0] resp, logic [31:0] a,
                              logic [1:0] t, logic w, logic [31:0] au);
    out_t o;
    o.sel = sel; o.held = held; o.rdy = rdy; o.resp = resp; o.addr = a; o.trans = t; o.write = w;
    o.size = a[26:24]; o.burst = a[22:20]; o.prot = a[19:16]; o.lock = a[28];
    o.auser = AU ? au : 32'h0;
    return o;
  endfunction
  function automatic out_t pt();
    return mk(HSELS, 1'b0, readyout_ip, resp_ip, HADDRS, HTRANSS, HWRITES, HAUSERS);
  endfunction
  function automatic out_t hold(logic [31:0] a, logic w, logic [31:0] au);
    return mk(1'b1, 1'b1, 1'b0, 2'b00, a, NS, w, au);
  endfunction
  task automatic drive(input logic sel, input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic rdys, input logic act, input logic rdo, input logic [1:0] rsp,
                       input logic [31:0] au);
    HSELS = sel; HADDRS = a; HTRANSS = t; HWRITES = w; HREADYS = rdys;
    HSIZES = a[26:24]; HBURSTS = a[22:20]; HPROTS = a[19:16]; HMASTLOCKS = a[28];
    active_ip = act; readyout_ip = rdo; resp_ip = rsp; HAUSERS = au;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1, 32'h1357_2468, NS, 1, 1, 0, 1, 2'b00, 32'hCAFE_0001);
        1: drive(1, 32'h0246_8ACE, NS, 0, 1, 0, 0, 2'b01, 32'hCAFE_0002);
        default: drive(0, 32'h0000_0000, IDL, 0, 1, 0, 1, 2'b00, 32'h0);
      endcase
      sb.push_back(pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL reset c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
    HRESETn = 1'b1;
  endtask
  task automatic test_pass();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1, 32'h0001_0004, NS, 0, 1, 1, 1, 2'b00, 32'h1111_2222);
        1: drive(1, 32'h0001_0008, SQ, 1, 1, 1, 0, 2'b00, 32'h3333_4444);
        default: drive(0, 32'h0001_000C, IDL, 0, 0, 1, 1, 2'b00, 32'h0);
      endcase
      sb.push_back(pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL pass c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  task automatic test_hold();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1, 32'h1000_0010, NS, 1, 1, 0, 1, 2'b00, 32'h5A5A_5A5A);
        1: drive(0, 32'hDEAD_0000, IDL, 0, 0, 0, 1, 2'b10, 32'h1234_5678);
        2: drive(0, 32'hBEEF_0000, IDL, 0, 1, 0, 1, 2'b00, 32'h1234_5678);
        3: drive(0, 32'hDEAD_0000, IDL, 0, 0, 1, 1, 2'b00, 32'h1234_5678);
        default: drive(0, 32'hDEAD_0000, IDL, 0, 1, 1, 1, 2'b00, 32'h0);
      endcase
      sb.push_back((c >= 1 && c <= 3) ? hold(32'h1000_0010, 1'b1, 32'h5A5A_5A5A) : pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL hold c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  task automatic test_idle_busy();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(1, 32'h4000_0000, BSY, 0, 1, 0, 1, 2'b00, 32'h0);
        1: drive(1, 32'h4000_0004, IDL, 0, 1, 0, 0, 2'b00, 32'h0);
        2: drive(1, 32'h4000_0008, IDL, 1, 0, 0, 1, 2'b00, 32'h0);
        default: drive(0, 32'h4000_000C, IDL, 0, 1, 0, 1, 2'b00, 32'h0);
      endcase
      sb.push_back(pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL idle c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  task automatic test_error();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(1, 32'h3000_0000, NS, 0, 1, 1, 1, 2'b00, 32'h0);
        1: drive(1, 32'h3000_0040, NS, 0, 0, 1, 0, 2'b01, 32'h0);
        2: drive(1, 32'h3000_0040, IDL, 0, 1, 0, 1, 2'b01, 32'h0);
        default: drive(0, 32'h3000_0080, IDL, 0, 1, 0, 1, 2'b00, 32'h0);
      endcase
      sb.push_back(pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL error c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  task automatic test_reset_mid_hold();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1, 32'h2000_0020, NS, 1, 1, 0, 1, 2'b00, 32'hA5A5_A5A5);
        1: drive(0, 32'h5555_0000, IDL, 0, 0, 0, 1, 2'b00, 32'h0);
        2: begin HRESETn = 1'b0; drive(0, 32'h5555_0000, IDL, 0, 0, 0, 1, 2'b00, 32'h0); end
        default: begin HRESETn = 1'b1; drive(0, 32'h5555_0000, IDL, 0, 1, 0, 1, 2'b00, 32'h0); end
      endcase
      sb.push_back(c == 1 ? hold(32'h2000_0020, 1'b1, 32'hA5A5_A5A5) : pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL rst_hold c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(1, 32'h6000_0000, NS, 1, 1, 0, 1, 2'b00, 32'h0000_AAAA);
        1: drive(1, 32'h6B30_0100, NS, 0, 0, 0, 1, 2'b00, 32'h0000_BBBB);
        2: drive(1, 32'h6B30_0100, NS, 0, 0, 1, 1, 2'b00, 32'h0000_BBBB);
        3: drive(1, 32'h6B30_0100, NS, 0, 1, 0, 1, 2'b00, 32'h0000_BBBB);
        4: drive(0, 32'h7000_0000, IDL, 0, 0, 0, 1, 2'b00, 32'h0);
        5: drive(0, 32'h7000_0000, IDL, 0, 0, 1, 1, 2'b00, 32'h0);
        default: drive(0, 32'h7000_0000, IDL, 0, 1, 1, 1, 2'b00, 32'h0);
      endcase
      sb.push_back((c == 1 || c == 2) ? hold(32'h6000_0000, 1'b1, 32'h0000_AAAA) :
                   (c == 4 || c == 5) ? hold(32'h6B30_0100, 1'b0, 32'h0000_BBBB) : pt());
      @(negedge HCLK);
      e = sb.pop_front(); checks++;
      if (obs !== e) $display("FAIL b2b c%0d: got %h expected %h", c, obs, e); else passed++;
      @(posedge HCLK); #1;
    end
  endtask
  initial begin
    test_reset();
    test_pass();
    test_hold();
    test_idle_busy();
    test_error();
    test_reset_mid_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
